// File: rtl/sdram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_read_arbiter
// Function : Round-robin arbiter sharing one AVMM SDRAM read master among
//            NREQ read requesters, tracking accepted-but-unreturned reads.
// Options  : define ARB_HOLD_LIMIT_EN to release a grant after HOLD_MAX
//            accepted reads whenever another requester is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_read_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_OUTST = 16,
    parameter int HOLD_MAX  = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_read,
    input  logic [32*NREQ-1:0]   req_address,
    input  logic [2*NREQ-1:0]    req_byteenable,
    output logic [NREQ-1:0]      req_waitrequest,
    output logic [NREQ-1:0]      req_readdatavalid,
    output logic [15:0]          req_readdata,
    output logic                 avm_m0_read,
    output logic [31:0]          avm_m0_address,
    output logic [1:0]           avm_m0_byteenable,
    input  logic [15:0]          avm_m0_readdata,
    input  logic                 avm_m0_readdatavalid,
    input  logic                 avm_m0_waitrequest
);

    localparam int c_GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_OW = $clog2(MAX_OUTST + 1);
    localparam int c_HW = $clog2(HOLD_MAX + 1);

    localparam logic [c_OW-1:0] c_OUTST_FULL = c_OW'(MAX_OUTST);
    localparam logic [c_HW-1:0] c_HOLD_LIMIT = c_HW'(HOLD_MAX);
    localparam logic [c_GW-1:0] c_LAST_INIT  = c_GW'(NREQ - 1);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic c_HOLD_EN = 1'b1;
`else
    localparam logic c_HOLD_EN = 1'b0;
`endif

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BUSY  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]      r_state, w_state_nxt;
    logic [c_GW-1:0] r_grant, w_grant_nxt;
    logic [c_GW-1:0] r_last_grant, w_last_grant_nxt;
    logic [c_OW-1:0] r_outst;
    logic [c_HW-1:0] r_hold_cnt;

    logic [c_GW-1:0] w_scan;
    logic [c_GW-1:0] w_rr_idx;
    logic            w_rr_found;
    logic            w_owner_read;
    logic            w_others_pending;
    logic            w_outst_full;
    logic            w_hold_hit;
    logic            w_stall;
    logic            w_accept;
    logic            w_rdv_ok;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_scan     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan = c_GW'((int'(r_last_grant) + k) % NREQ);
            if (!w_rr_found && req_read[w_scan]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan;
            end
        end
    end

    assign w_owner_read     = req_read[r_grant];
    assign w_others_pending = |(req_read & ~(NREQ'(1) << r_grant));
    assign w_outst_full     = (r_outst == c_OUTST_FULL);
    assign w_hold_hit       = c_HOLD_EN && (r_state == c_ST_BUSY) && (r_hold_cnt == c_HOLD_LIMIT);
    assign w_stall          = w_outst_full || w_hold_hit;
    assign w_accept         = avm_m0_read && !avm_m0_waitrequest;
    // Data returning with nothing outstanding belongs to no one (e.g. pre-reset reads).
    assign w_rdv_ok         = avm_m0_readdatavalid && (r_outst != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_INIT;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rr_found) begin
                    w_state_nxt = c_ST_BUSY;
                    w_grant_nxt = w_rr_idx;
                end
            end
            c_ST_BUSY: begin
                if (!w_owner_read || (w_hold_hit && w_others_pending)) begin
                    w_state_nxt      = c_ST_DRAIN;
                    w_last_grant_nxt = r_grant;
                end
            end
            c_ST_DRAIN: begin
                if (r_outst == '0) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outstanding reads and per-grant accept count (saturating when unused).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outst    <= '0;
            r_hold_cnt <= '0;
        end else begin
            if (w_accept && !w_rdv_ok) begin
                r_outst <= r_outst + 1'b1;
            end else if (w_rdv_ok && !w_accept) begin
                r_outst <= r_outst - 1'b1;
            end
            if ((r_state != c_ST_BUSY) || w_hold_hit) begin
                r_hold_cnt <= '0;
            end else if (w_accept && (r_hold_cnt != c_HOLD_LIMIT)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        avm_m0_read       = 1'b0;
        avm_m0_address    = '0;
        avm_m0_byteenable = '0;
        case (r_state)
            c_ST_BUSY: begin
                avm_m0_read                = w_owner_read && !w_stall;
                avm_m0_address             = req_address[32*r_grant +: 32];
                avm_m0_byteenable          = req_byteenable[2*r_grant +: 2];
                req_waitrequest[r_grant]   = avm_m0_waitrequest || w_stall;
                req_readdatavalid[r_grant] = w_rdv_ok;
            end
            c_ST_DRAIN: begin
                req_readdatavalid[r_grant] = w_rdv_ok;
            end
            default: ;
        endcase
    end

    assign req_readdata = avm_m0_readdata;

endmodule
`default_nettype wire

// File: tb/tb_sdram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_read_arbiter
// Function : Random requesters and SDRAM slave against a reference model of
//            the arbitration, throttling and response-routing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_read_arbiter;

    localparam int          c_NREQ      = 4;
    localparam int          c_MAX_OUTST = 4;
    localparam int          c_HOLD_MAX  = 9;
    localparam int          c_N_CYCLES  = 4000;
    localparam logic [15:0] c_DATA_KEY  = 16'hC3A5;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit          c_HOLD_EN   = 1'b1;
`else
    localparam bit          c_HOLD_EN   = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic [c_NREQ-1:0]      req_read;
    logic [32*c_NREQ-1:0]   req_address;
    logic [2*c_NREQ-1:0]    req_byteenable;
    logic [c_NREQ-1:0]      req_waitrequest;
    logic [c_NREQ-1:0]      req_readdatavalid;
    logic [15:0]            req_readdata;
    logic                   avm_m0_read;
    logic [31:0]            avm_m0_address;
    logic [1:0]             avm_m0_byteenable;
    logic [15:0]            avm_m0_readdata;
    logic                   avm_m0_readdatavalid;
    logic                   avm_m0_waitrequest;

    sdram_read_arbiter #(
        .NREQ      (c_NREQ),
        .MAX_OUTST (c_MAX_OUTST),
        .HOLD_MAX  (c_HOLD_MAX)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_read             (req_read),
        .req_address          (req_address),
        .req_byteenable       (req_byteenable),
        .req_waitrequest      (req_waitrequest),
        .req_readdatavalid    (req_readdatavalid),
        .req_readdata         (req_readdata),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_byteenable    (avm_m0_byteenable),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .avm_m0_waitrequest   (avm_m0_waitrequest)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 owned, 2 draining.
    int m_phase, m_owner, m_last, m_outst, m_held;
    bit t_acc, t_rdv_ok;
    logic [15:0] exp_data_q[$];

    // SDRAM slave: in-order responses with random latency.
    int          sl_ready_q[$];
    logic [15:0] sl_data_q[$];
    int          sl_last;
    int          cyc;

    // Requesters.
    bit          act   [c_NREQ];
    logic [31:0] raddr [c_NREQ];
    logic [1:0]  rbe   [c_NREQ];
    int          gap   [c_NREQ];
    int          quiet;
    bit          reset_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_idle(input string where);
        check({where, "_avm_read"}, 32'(avm_m0_read), 32'd0);
        check({where, "_avm_address"}, avm_m0_address, 32'd0);
        check({where, "_avm_byteenable"}, 32'(avm_m0_byteenable), 32'd0);
        check({where, "_waitrequest"}, 32'(req_waitrequest), 32'hF);
        check({where, "_readdatavalid"}, 32'(req_readdatavalid), 32'd0);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < c_NREQ; i++) begin
            if (!act[i] && quiet == 0) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else begin
                    act[i]   = 1'b1;
                    raddr[i] = $urandom;
                    rbe[i]   = 2'($urandom_range(1, 3));
                end
            end
            req_read[i]              = act[i];
            req_address[32*i +: 32]  = raddr[i];
            req_byteenable[2*i +: 2] = rbe[i];
        end
        if (quiet > 0 && sl_ready_q.size() == 0) quiet--;
        avm_m0_waitrequest = ($urandom_range(0, 3) == 0);
        if (sl_ready_q.size() > 0 && sl_ready_q[0] <= cyc) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = sl_data_q.pop_front();
            void'(sl_ready_q.pop_front());
        end else if (sl_ready_q.size() == 0 && $urandom_range(0, 15) == 0) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = 16'($urandom);
        end else begin
            avm_m0_readdatavalid = 1'b0;
            avm_m0_readdata      = 16'($urandom);
        end
    endtask

    task automatic check_cycle();
        logic              exp_read;
        logic [31:0]       exp_addr;
        logic [1:0]        exp_be;
        logic [c_NREQ-1:0] exp_wait, exp_rdv;
        bit                blocked;
        exp_read = 1'b0;
        exp_addr = '0;
        exp_be   = '0;
        exp_wait = '1;
        exp_rdv  = '0;
        t_rdv_ok = avm_m0_readdatavalid && (m_outst > 0);
        blocked  = (m_outst == c_MAX_OUTST) || (c_HOLD_EN && m_held == c_HOLD_MAX);
        if (m_phase == 1) begin
            exp_read          = req_read[m_owner] && !blocked;
            exp_addr          = req_address[32*m_owner +: 32];
            exp_be            = req_byteenable[2*m_owner +: 2];
            exp_wait[m_owner] = blocked || avm_m0_waitrequest;
        end
        if (t_rdv_ok) exp_rdv[m_owner] = 1'b1;
        t_acc = exp_read && !avm_m0_waitrequest;

        check("avm_read", 32'(avm_m0_read), 32'(exp_read));
        if (m_phase != 2) begin
            check("avm_address", avm_m0_address, exp_addr);
            check("avm_byteenable", 32'(avm_m0_byteenable), 32'(exp_be));
        end
        check("req_waitrequest", 32'(req_waitrequest), 32'(exp_wait));
        check("req_readdatavalid", 32'(req_readdatavalid), 32'(exp_rdv));
        check("req_readdata", 32'(req_readdata), 32'(avm_m0_readdata));
        if (t_rdv_ok && exp_data_q.size() > 0) begin
            check("resp_data", 32'(req_readdata), 32'(exp_data_q.pop_front()));
        end
    endtask

    task automatic update_model();
        bit others;
        int ready;
        others = 1'b0;
        for (int i = 0; i < c_NREQ; i++) begin
            if (i != m_owner && req_read[i]) others = 1'b1;
        end
        if (t_acc) begin
            ready = cyc + int'($urandom_range(1, 8));
            if (ready <= sl_last) ready = sl_last + 1;
            sl_last = ready;
            sl_ready_q.push_back(ready);
            sl_data_q.push_back(avm_m0_address[15:0] ^ c_DATA_KEY);
            exp_data_q.push_back(raddr[m_owner][15:0] ^ c_DATA_KEY);
            if ($urandom_range(0, 7) < 6) begin
                raddr[m_owner] = $urandom;
                rbe[m_owner]   = 2'($urandom_range(1, 3));
            end else begin
                act[m_owner] = 1'b0;
                gap[m_owner] = $urandom_range(0, 5);
            end
        end
        case (m_phase)
            0: begin
                if (req_read != '0) begin
                    for (int k = c_NREQ; k >= 1; k--) begin
                        if (req_read[(m_last + k) % c_NREQ]) m_owner = (m_last + k) % c_NREQ;
                    end
                    m_phase = 1;
                    m_held  = 0;
                end
            end
            1: begin
                if (!req_read[m_owner] || (c_HOLD_EN && m_held == c_HOLD_MAX && others)) begin
                    m_phase = 2;
                    m_last  = m_owner;
                end else if (c_HOLD_EN && m_held == c_HOLD_MAX) begin
                    m_held = 0;
                end else if (t_acc) begin
                    m_held++;
                end
            end
            default: begin
                if (m_outst == 0) m_phase = 0;
            end
        endcase
        m_outst = m_outst + (t_acc ? 1 : 0) - (t_rdv_ok ? 1 : 0);
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        check_idle("midreset");
        m_phase = 0;
        m_owner = 0;
        m_last  = c_NREQ - 1;
        m_outst = 0;
        m_held  = 0;
        exp_data_q.delete();
        for (int i = 0; i < c_NREQ; i++) begin
            act[i] = 1'b0;
            gap[i] = 0;
        end
        quiet = 3;
    endtask

    initial begin
        reset                = 1'b0;
        req_read             = '0;
        req_address          = '0;
        req_byteenable       = '0;
        avm_m0_readdata      = '0;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_waitrequest   = 1'b0;
        m_phase = 0; m_owner = 0; m_last = c_NREQ - 1; m_outst = 0; m_held = 0;
        t_acc = 1'b0; t_rdv_ok = 1'b0;
        cyc = 0; sl_last = 0; quiet = 0; reset_done = 1'b0;
        for (int i = 0; i < c_NREQ; i++) begin
            act[i]   = 1'b0;
            gap[i]   = $urandom_range(0, 3);
            raddr[i] = '0;
            rbe[i]   = '0;
        end
        #1;
        reset                = 1'b1;
        req_read             = '1;
        req_address          = {c_NREQ{32'h1234_5678}};
        req_byteenable       = '1;
        avm_m0_readdatavalid = 1'b1;
        #1;
        check_idle("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset_held");
        req_read             = '0;
        avm_m0_readdatavalid = 1'b0;

        for (int n = 0; n < c_N_CYCLES; n++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            cyc++;
            drive_inputs();
            @(negedge clk);
            check_cycle();
            if (!reset_done && cyc > 1500 && m_outst >= 2) begin
                reset_done = 1'b1;
                mid_reset();
            end else begin
                update_model();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
